// File: rtl/toycpu_pkg.sv
// Shared sizing and types for the toy CPU and its scan-loaded memory.
// Holds bus widths, memory depth, scan image length and word/address types.
package toycpu_pkg;

    localparam int unsigned ADDR_W   = 4;
    localparam int unsigned DATA_W   = 8;
    localparam int unsigned DEPTH    = 1 << ADDR_W;
    localparam int unsigned SCAN_LEN = DEPTH * DATA_W;
    localparam int unsigned CNT_W    = $clog2(SCAN_LEN);

    typedef logic [ADDR_W-1:0] addr_t;
    typedef logic [DATA_W-1:0] word_t;
    typedef logic [CNT_W-1:0]  cnt_t;

endpackage

// File: rtl/toycpu_scan_mem.sv
// 16x8 CPU data/program memory with a bit-serial scan chain for load/readout.
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   scan_en, scan_in    : shift enable and serial input (enters word 0 bit 0)
//   scan_out            : serial output (word DEPTH-1 bit DATA_W-1)
//   cpu_addr/wdata/we   : CPU bus address, write data, write enable
//   cpu_rdata           : combinational read of mem[cpu_addr]
//   bit_cnt, load_done  : bits shifted in current image, image-complete pulse
module toycpu_scan_mem
    import toycpu_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              scan_en,
    input  logic              scan_in,
    output logic              scan_out,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    input  logic              cpu_we,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic [CNT_W-1:0]  bit_cnt,
    output logic              load_done
);

    word_t [DEPTH-1:0] mem_q;
    word_t [DEPTH-1:0] mem_d;
    word_t [DEPTH-1:0] shift_w;

    cnt_t bit_cnt_q;
    cnt_t bit_cnt_d;
    logic load_done_q;
    logic load_done_d;
    logic wrap_w;

    // The array is one long chain: bit b of word i takes the bit below it,
    // and bit 0 of word i takes the MSB of word i-1.
    for (genvar i = 0; i < int'(DEPTH); i++) begin : g_word
        for (genvar b = 0; b < int'(DATA_W); b++) begin : g_bit
            if (i == 0 && b == 0) begin : g_head
                assign shift_w[i][b] = scan_in;
            end else if (b == 0) begin : g_link
                assign shift_w[i][b] = mem_q[i-1][DATA_W-1];
            end else begin : g_body
                assign shift_w[i][b] = mem_q[i][b-1];
            end
        end
    end

    // Shifting owns the array; a CPU write in the same cycle is dropped.
    always_comb begin
        mem_d = mem_q;
        if (scan_en) begin
            mem_d = shift_w;
        end else if (cpu_we) begin
            mem_d[cpu_addr] = cpu_wdata;
        end
    end

    assign wrap_w = (bit_cnt_q == CNT_W'(SCAN_LEN - 1));

    always_comb begin
        bit_cnt_d   = bit_cnt_q;
        load_done_d = 1'b0;
        if (scan_en) begin
            bit_cnt_d   = wrap_w ? '0 : bit_cnt_q + CNT_W'(1);
            load_done_d = wrap_w;
        end
    end

    // Contents are deliberately not reset so results survive a CPU reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            mem_q <= mem_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bit_cnt_q   <= '0;
            load_done_q <= 1'b0;
        end else begin
            bit_cnt_q   <= bit_cnt_d;
            load_done_q <= load_done_d;
        end
    end

    assign cpu_rdata = mem_q[cpu_addr];
    assign scan_out  = mem_q[DEPTH-1][DATA_W-1];
    assign bit_cnt   = bit_cnt_q;
    assign load_done = load_done_q;

endmodule
